// File: rtl/vc_drain_arbiter.sv
// vc_drain_arbiter: round-robin drain of four class FIFOs (P0..P3) onto one
// downstream FIFO, one word per cycle, with threshold capture during INIT and
// throttling on the downstream almost-full flag.
module vc_drain_arbiter #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [2:0]              umbral_bajo_in,
  input  logic [2:0]              umbral_alto_in,
  output logic [2:0]              umbral_bajo,
  output logic [2:0]              umbral_alto,
  input  logic [3:0]              src_empty,
  input  logic [4*DATA_WIDTH-1:0] src_data,
  output logic [3:0]              src_pop,
  input  logic                    dst_almost_full,
  output logic                    dst_push,
  output logic [DATA_WIDTH-1:0]   dst_data,
  output logic [1:0]              grant_idx,
  output logic [1:0]              state,
  output logic                    idle
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [1:0]            ptr_reg;
  logic [2:0]            umbral_bajo_reg;
  logic [2:0]            umbral_alto_reg;
  logic                  dst_push_reg;
  logic [DATA_WIDTH-1:0] dst_data_reg;
  logic [1:0]            grant_idx_reg;

  logic [DATA_WIDTH-1:0] src_word [4];
  logic [1:0]            cand_idx [4];
  logic [3:0]            cand_ok;
  logic                  sel_valid;
  logic [1:0]            sel_idx;
  logic                  any_src;
  logic                  grant;

  // Unpack head words and build the scan order ptr, ptr+1, ... (mod 4).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
      assign src_word[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign cand_idx[gi] = ptr_reg + 2'(gi);
      assign cand_ok[gi]  = !src_empty[cand_idx[gi]];
    end
  endgenerate

  assign any_src = ~&src_empty;

  // Pick the first non-empty source in rotated order (lowest offset wins).
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (cand_ok[k]) begin
        sel_valid = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  // A grant only happens in ACTIVE; reset, init and almost-full all veto it,
  // so a pop never reaches a FIFO during reset or an INIT request.
  assign grant   = (state_reg == ST_ACTIVE) && !reset && !init &&
                   !dst_almost_full && sel_valid;
  assign src_pop = grant ? (4'b0001 << sel_idx) : 4'b0000;

  // Next-state selection for the configuration / drain sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT:   if (!init) state_next = ST_IDLE;
      ST_IDLE: begin
        if (init)         state_next = ST_INIT;
        else if (any_src) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)          state_next = ST_INIT;
        else if (!any_src) state_next = ST_IDLE;
      end
      default:   state_next = ST_RESET;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_RESET;
    else       state_reg <= state_next;
  end

  // Thresholds track the inputs while in INIT and are frozen otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      umbral_bajo_reg <= 3'd0;
      umbral_alto_reg <= 3'd0;
    end else if (state_reg == ST_INIT) begin
      umbral_bajo_reg <= umbral_bajo_in;
      umbral_alto_reg <= umbral_alto_in;
    end
  end

  // Registered push path: the popped word lands downstream one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_push_reg  <= 1'b0;
      dst_data_reg  <= '0;
      grant_idx_reg <= 2'd0;
      ptr_reg       <= 2'd0;
    end else begin
      dst_push_reg <= grant;
      if (grant) begin
        dst_data_reg  <= src_word[sel_idx];
        grant_idx_reg <= sel_idx;
        ptr_reg       <= sel_idx + 2'd1;
      end
    end
  end

  assign umbral_bajo = umbral_bajo_reg;
  assign umbral_alto = umbral_alto_reg;
  assign dst_push    = dst_push_reg;
  assign dst_data    = dst_data_reg;
  assign grant_idx   = grant_idx_reg;
  assign state       = state_reg;
  assign idle        = (state_reg == ST_IDLE) && (&src_empty);

endmodule
